// File: rtl/clk_div_ratio_checker.sv
// clk_div_ratio_checker
//   Receive-side monitor for a clock divided down from clk. The divided clock
//   is resynchronised, its period and high time are measured in clk cycles,
//   and each measurement is checked against the expected ratio. Lock is
//   declared after LOCK_CNT consecutive good periods; any bad period or a
//   missing edge (timeout) raises a sticky error and bumps an error counter.
//
// Ports
//   clk            in   1      system clock (source of the divided clock)
//   reset          in   1      asynchronous, active-high reset
//   i_chk_en       in   1      check enable; low returns the checker to IDLE
//   i_div_clk      in   1      divided clock under test
//   o_period       out  CNT_W  last measured period (clk cycles)
//   o_high_cnt     out  CNT_W  last measured high time (clk cycles)
//   o_period_valid out  1      one-cycle pulse when o_period/o_high_cnt update
//   o_locked       out  1      LOCK_CNT consecutive good periods seen
//   o_err          out  1      sticky error flag
//   o_err_cnt      out  8      saturating error count

module clk_div_ratio_checker #(
  parameter int EXP_DIV  = 7,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_chk_en,
  input  logic             i_div_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic [7:0]       o_err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] HIGH_LO = CNT_W'(EXP_DIV / 2);
  localparam logic [CNT_W-1:0] HIGH_HI = CNT_W'((EXP_DIV + 1) / 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync_prev_q;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             rise_s;
  logic             good_s;
  logic [7:0]       err_cnt_inc_s;

  assign rise_s        = sync2_q & ~sync_prev_q;
  // The counters already hold the full period when the closing rise arrives.
  assign good_s        = (period_cnt_q == EXP_P) &&
                         ((high_cnt_q == HIGH_LO) || (high_cnt_q == HIGH_HI));
  assign err_cnt_inc_s = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);

  // Synchronizer, edge register and all state/output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync_prev_q  <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= {CNT_W{1'b0}};
      high_cnt_q   <= {CNT_W{1'b0}};
      match_q      <= {MW{1'b0}};
      period_q     <= {CNT_W{1'b0}};
      high_q       <= {CNT_W{1'b0}};
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      sync1_q      <= i_div_clk;
      sync2_q      <= sync1_q;
      sync_prev_q  <= sync2_q;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      match_q      <= match_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state, measurement and error/lock bookkeeping.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    match_d      = match_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;

    if (!i_chk_en) begin
      // Disabling the checker wipes status but keeps the last measurement.
      state_d   = IDLE;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
      match_d   = {MW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = WAIT_EDGE;
          locked_d  = 1'b0;
          err_d     = 1'b0;
          err_cnt_d = 8'd0;
          match_d   = {MW{1'b0}};
        end
        WAIT_EDGE: begin
          // First edge is only a reference point; the rise cycle is cycle 1.
          if (rise_s) begin
            state_d      = MEASURE;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else begin
            state_d      = WAIT_EDGE;
          end
        end
        MEASURE, LOCKED: begin
          // A rise on the timeout cycle still closes a normal measurement.
          if (rise_s) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            if (good_s) begin
              if (state_q == LOCKED) begin
                state_d  = LOCKED;
              end else if (match_q == MW'(LOCK_CNT - 1)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                match_d  = MW'(LOCK_CNT);
              end else begin
                match_d  = match_q + MW'(1);
              end
            end else begin
              state_d   = MEASURE;
              locked_d  = 1'b0;
              err_d     = 1'b1;
              err_cnt_d = err_cnt_inc_s;
              match_d   = {MW{1'b0}};
            end
          end else if (period_cnt_q == CNT_MAX) begin
            // Missing edge: one error, then resynchronise on a fresh reference.
            state_d   = WAIT_EDGE;
            locked_d  = 1'b0;
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc_s;
            match_d   = {MW{1'b0}};
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            high_cnt_d   = high_cnt_q + {{(CNT_W-1){1'b0}}, sync2_q};
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_period       = period_q;
  assign o_high_cnt     = high_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_err          = err_q;
  assign o_err_cnt      = err_cnt_q;

endmodule
